// File: rtl/booth_seq_mult_pkg.sv
// Shared state encodings and Booth recoding decode for the sequential Booth multiplier.
package booth_seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_e;

  // Radix-2 Booth recoding of the {Q[0], Q-1} bit pair.
  function automatic op_e booth_op(input logic q0, input logic qm1);
    case ({q0, qm1})
      2'b10:   return OP_SUB;
      2'b01:   return OP_ADD;
      default: return OP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_mult_addsub.sv
// Combinational ripple add/subtract, sum = a + (m ^ {W{sub}}) + sub, modulo 2^W.
// Zero latency, no flow control; the carry-out is dropped.
module booth_seq_mult_addsub #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic         sub,
  output logic [W-1:0] sum
);

  always_comb begin
    logic c;
    logic mx;
    sum = '0;
    c   = sub;
    mx  = 1'b0;
    for (int i = 0; i < W; i++) begin
      mx     = m[i] ^ sub;
      sum[i] = a[i] ^ mx ^ c;
      c      = (a[i] & mx) | (c & (a[i] ^ mx));
    end
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier; done pulses 2*WIDTH edges after start is accepted (ready=1).
// Busy operations ignore start. BOOTH_ZERO_SKIP_EN: zero operand completes on the accepting edge.
module booth_seq_mult
  import booth_seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     m_in,
  input  logic [WIDTH-1:0]     q_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int AW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      a_q, a_d;
  logic [AW-1:0]      m_q, m_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               done_q, done_d;

  op_e                op;
  logic               sub;
  logic [AW-1:0]      sum;

  assign op  = booth_op(q_q[0], qm1_q);
  assign sub = (op == OP_SUB);

  booth_seq_mult_addsub #(.W(AW)) u_addsub (
    .a   (a_q),
    .m   (m_q),
    .sub (sub),
    .sum (sum)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
          if ((m_in == '0) || (q_in == '0)) begin
            prod_d = '0;
            done_d = 1'b1;
          end else begin
            a_d     = '0;
            m_d     = {m_in[WIDTH-1], m_in};
            q_d     = q_in;
            qm1_d   = 1'b0;
            cnt_d   = CW'(WIDTH);
            state_d = ST_ADD;
          end
`else
          a_d     = '0;
          m_d     = {m_in[WIDTH-1], m_in};
          q_d     = q_in;
          qm1_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
          state_d = ST_ADD;
`endif
        end
      end
      ST_ADD: begin
        if (op != OP_NONE) begin
          a_d = sum;
        end
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        // Arithmetic shift of {A,Q,Q-1}: the old Q-1 falls off the end.
        {a_d, q_d, qm1_d} = {a_q[AW-1], a_q, q_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          prod_d  = {a_d[WIDTH-1:0], q_d};
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ADD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE);
  assign busy  = ~ready;
  assign done  = done_q;
  assign prod  = prod_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed-vector bench for booth_seq_mult (WIDTH=8) with hand-computed products and latencies.
module tb_booth_seq_mult;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  m_in;
  logic [7:0]  q_in;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] prod;

  int nvec = 0;
  int nmis = 0;

  booth_seq_mult #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m_in  (m_in),
    .q_in  (q_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Edges after the accepting edge until done is seen (0 = done right after accept).
  task automatic wait_done(output int lat);
    lat = -1;
    if (done) begin
      lat = 0;
    end else begin
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] exp_prod, input int exp_lat);
    int lat;
    @(negedge clk);
    start = 1'b1; m_in = m; q_in = q;
    @(posedge clk); #1;
    start = 1'b0; m_in = 8'hxx; q_in = 8'hxx;
    wait_done(lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_prod"}, prod, exp_prod);
    chk({tag, "_rdy"}, ready, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  initial begin
    int lat;
    int pulses;
    int zlat;
    rst = 1'b1; start = 1'b0; m_in = '0; q_in = '0;
    #12;
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_prod", prod, 16'h0000);
    @(negedge clk); rst = 1'b0;

    // Reset in the middle of an operation (edge 7 counting the accepting edge).
    @(negedge clk);
    start = 1'b1; m_in = 8'd3; q_in = 8'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mid_busy", busy, 1'b1);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_prod", prod, 16'h0000);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("mid_no_done", pulses, 0);

    run_op("p3x5", 8'd3, 8'd5, 16'h000F, 16);
    run_op("n3x5", 8'hFD, 8'd5, 16'hFFF1, 16);
    run_op("p5xn3", 8'd5, 8'hFD, 16'hFFF1, 16);
    run_op("min_min", 8'h80, 8'h80, 16'h4000, 16);
    run_op("max_min", 8'h7F, 8'h80, 16'hC080, 16);
    run_op("n1xn1", 8'hFF, 8'hFF, 16'h0001, 16);
    run_op("max_max", 8'h7F, 8'h7F, 16'h3F01, 16);

    // start held high with changing operands, then back-to-back accept on the done cycle.
    @(negedge clk);
    start = 1'b1; m_in = 8'd3; q_in = 8'd5;
    @(posedge clk); #1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      m_in = 8'($urandom); q_in = 8'($urandom);
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    chk("hold_lat", lat, 16);
    chk("hold_prod", prod, 16'h000F);
    m_in = 8'd7; q_in = 8'hFE;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_clr", done, 1'b0);
    chk("b2b_busy", busy, 1'b1);
    wait_done(lat);
    chk("b2b_lat", lat, 16);
    chk("b2b_prod", prod, 16'hFFF2);
    @(posedge clk); #1;

`ifdef BOOTH_ZERO_SKIP_EN
    zlat = 0;
`else
    zlat = 16;
`endif
    run_op("zero_m", 8'd0, 8'd77, 16'h0000, zlat);
    run_op("p3x5_again", 8'd3, 8'd5, 16'h000F, 16);
    run_op("zero_q", 8'd77, 8'd0, 16'h0000, zlat);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
